caldet_mxb_datapath: RTL and testbench
======================================

// Module: caldet_mxb_datapath
// PURPOSE
//   Consumer end of the caldetMxB enable/read-address interface. The control block drives
//   encaldetMxB and fixed read addresses 0..3 into the matrix B storage. This block takes the
//   four returned elements (row-major a,b,c,d of a 2x2 signed matrix) and computes
//   det = a*d - b*c over a small multi-cycle FSM. It presents the result plus a one-cycle
//   valid strobe to the divider datapath.
// PARAMETERS
//   DW  8  signed width of one matrix element; result width is 2*DW+1
// PORTS
//   clk          in   1       system clock, all state on rising edge
//   rst          in   1       synchronous reset, active-high
//   encaldetMxB  in   1       level enable from control; stays high while start is held
//   rd1MxB       in   DW      element a (address 0), signed
//   rd2MxB       in   DW      element b (address 1), signed
//   rd3MxB       in   DW      element c (address 2), signed
//   rd4MxB       in   DW      element d (address 3), signed
//   detMxB       out  2*DW+1  signed determinant, registered, held until next result
//   detvalidMxB  out  1       one-cycle strobe: detMxB updated this cycle
//   busyMxB      out  1       high while a computation is in flight (MUL1, MUL2, SUB)
// BEHAVIOUR
//   Reset (rst=1 at a clock edge):
//     - state=IDLE; detMxB, detvalidMxB, busyMxB, operand and product regs all 0.
//     - Reset wins over every other event.
//   FSM states: IDLE, MUL1, MUL2, SUB, HOLD.
//     - IDLE: if encaldetMxB=1, latch rd1..rd4 into a,b,c,d and go to MUL1; else stay.
//       rd* are high-Z/X whenever the enable is low and are sampled only here.
//     - MUL1: p1 <= a*d (signed, 2*DW); go to MUL2.
//     - MUL2: p2 <= b*c (signed, 2*DW); go to SUB.
//     - SUB: detMxB <= sext(p1) - sext(p2) (2*DW+1, never overflows); detvalidMxB <= 1;
//       go to HOLD.
//     - HOLD: detvalidMxB <= 0; stay while encaldetMxB=1; go to IDLE when it is 0.
//   Retrigger:
//     - One computation per enable assertion; a held-high enable never retriggers.
//     - Enable dropping during MUL1/MUL2/SUB does not abort; the result still completes.
//   Latency: enable sampled high at edge N -> detvalidMxB high in the cycle after edge N+3.
//     - Minimum spacing between results is 5 cycles (enable must be seen low once in HOLD).
//   Outputs:
//     - busyMxB = (state is MUL1, MUL2 or SUB), decoded from registered state.
//     - detvalidMxB is registered and high for exactly one cycle per computation.
//     - detMxB changes only together with detvalidMxB (or reset).
//   Reset mid-operation: computation discarded, no detvalidMxB, detMxB=0, state=IDLE.
// TESTING
//   1. DW=8, a,b,c,d=3,1,2,4; enable pulsed 1 cycle -> detMxB=10 with detvalidMxB one cycle,
//      4 cycles after enable.
//   2. a=-128,d=-128,b=127,c=-128 -> detMxB=+32640; a=127,d=-128,b=-128,c=-128 -> -32640
//      (no overflow).
//   3. Enable held high 20 cycles -> exactly one detvalidMxB; drop, reassert with 0,5,7,0
//      -> second strobe, detMxB=-35.
//   4. rst asserted in MUL2 -> no strobe, detMxB=0, busyMxB=0 next cycle; next enable
//      computes normally.
//   5. rd* driven X while enable low, then valid on enable edge -> result uses only the
//      sampled values, no X on detMxB.
//   6. Enable dropped in MUL1 -> result still completes; busyMxB high exactly 3 cycles.

Source files
------------

// File: rtl/caldet_mxb_datapath.sv
// Determinant of a returned 2x2 signed matrix B (det = a*d - b*c).
// Uses a multi-cycle FSM and emits a one-cycle valid strobe per enable assertion.
module caldet_mxb_datapath #(
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            encaldetMxB,
  input  logic [DW-1:0]   rd1MxB,
  input  logic [DW-1:0]   rd2MxB,
  input  logic [DW-1:0]   rd3MxB,
  input  logic [DW-1:0]   rd4MxB,
  output logic [2*DW:0]   detMxB,
  output logic            detvalidMxB,
  output logic            busyMxB
);

  localparam int unsigned PW   = 2 * DW;
  localparam int unsigned DETW = 2 * DW + 1;

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, SUB, HOLD} state_t;

  state_t                 state, state_d;
  logic signed [DW-1:0]   a, b, c, d;
  logic signed [DW-1:0]   a_d, b_d, c_d, d_d;
  logic signed [PW-1:0]   p1, p2, p1_d, p2_d;
  logic [DETW-1:0]        det_d;
  logic                   valid_d;

  // State and datapath registers; reset discards any in-flight computation
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      p1          <= '0;
      p2          <= '0;
      detMxB      <= '0;
      detvalidMxB <= 1'b0;
    end else begin
      state       <= state_d;
      a           <= a_d;
      b           <= b_d;
      c           <= c_d;
      d           <= d_d;
      p1          <= p1_d;
      p2          <= p2_d;
      detMxB      <= det_d;
      detvalidMxB <= valid_d;
    end
  end

  // Next-state and datapath; operands are sampled only on the IDLE enable edge
  always_comb begin
    state_d = state;
    a_d     = a;
    b_d     = b;
    c_d     = c;
    d_d     = d;
    p1_d    = p1;
    p2_d    = p2;
    det_d   = detMxB;
    valid_d = 1'b0;
    case (state)
      IDLE: begin
        if (encaldetMxB) begin
          a_d     = rd1MxB;
          b_d     = rd2MxB;
          c_d     = rd3MxB;
          d_d     = rd4MxB;
          state_d = MUL1;
        end
      end
      MUL1: begin
        p1_d    = PW'(a) * PW'(d);
        state_d = MUL2;
      end
      MUL2: begin
        p2_d    = PW'(b) * PW'(c);
        state_d = SUB;
      end
      SUB: begin
        // Sign-extending both products by one bit makes the difference overflow-free
        det_d   = DETW'(p1) - DETW'(p2);
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (!encaldetMxB) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busyMxB = (state == MUL1) || (state == MUL2) || (state == SUB);

endmodule

// File: tb/tb_caldet_mxb_datapath.sv
// Bench for caldet_mxb_datapath: directed operand sets with hand-computed determinants.
// A monitor pops expected results from a queue whenever the strobe appears.
module tb_caldet_mxb_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  rd1, rd2, rd3, rd4;
  logic [16:0] det;
  logic        dvalid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  caldet_mxb_datapath #(.DW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .encaldetMxB (en),
    .rd1MxB      (rd1),
    .rd2MxB      (rd2),
    .rd3MxB      (rd3),
    .rd4MxB      (rd4),
    .detMxB      (det),
    .detvalidMxB (dvalid),
    .busyMxB     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected result
  always @(negedge clk) begin
    if (dvalid === 1'b1) begin
      logic signed [31:0] act;
      act = 32'($signed(det));
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got det %0d required no strobe", act);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (act !== 32'(e)) begin
          errors++;
          $display("FAIL det_value: got %0d required %0d", act, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation: enable held for en_cycles edges, observe for total steps
  task automatic do_op(input int a, input int b, input int c, input int d,
                       input int exp, input int en_cycles, input int total,
                       input string name);
    int strobes = 0;
    int lat = -1;
    int busy_cnt = 0;
    rd1 = 'x; rd2 = 'x; rd3 = 'x; rd4 = 'x;
    step();
    step();
    exp_q.push_back(exp);
    rd1 = 8'(a); rd2 = 8'(b); rd3 = 8'(c); rd4 = 8'(d);
    en = 1'b1;
    for (int i = 1; i <= total; i++) begin
      step();
      if (i == en_cycles) begin
        en = 1'b0;
        rd1 = 'x; rd2 = 'x; rd3 = 'x; rd4 = 'x;
      end
      if (busy === 1'b1) busy_cnt++;
      if (dvalid === 1'b1) begin
        strobes++;
        if (lat < 0) lat = i;
      end
    end
    check({name, "_strobes"}, strobes, 1);
    check({name, "_latency"}, lat, 4);
    check({name, "_busy_cycles"}, busy_cnt, 3);
    en = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    rd1 = '0; rd2 = '0; rd3 = '0; rd4 = '0;
    step();
    step();
    check("reset_det", 32'($signed(det)), 0);
    check("reset_valid", 32'(dvalid), 0);
    check("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    step();

    do_op(3, 1, 2, 4, 10, 1, 8, "basic");
    do_op(-128, 127, -128, -128, 32640, 1, 8, "max_pos");
    do_op(127, -128, -128, -128, -32640, 1, 8, "max_neg");
    do_op(2, 3, 4, 5, -2, 20, 24, "held_enable");
    do_op(0, 5, 7, 0, -35, 1, 8, "reassert");
    do_op(9, 2, 1, 3, 25, 2, 8, "drop_in_mul2");

    // Reset landing while the FSM is in MUL2 must discard the result
    rd1 = 8'(1); rd2 = 8'(1); rd3 = 8'(1); rd4 = 8'(1);
    en = 1'b1;
    step();
    en = 1'b0;
    step();
    check("pre_reset_busy", 32'(busy), 1);
    rst = 1'b1;
    step();
    check("midop_reset_det", 32'($signed(det)), 0);
    check("midop_reset_busy", 32'(busy), 0);
    check("midop_reset_valid", 32'(dvalid), 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();

    do_op(6, -2, 5, 7, 52, 1, 8, "after_reset");

    for (int i = 0; i < 4; i++) step();
    check("queue_drained", exp_q.size(), 0);
    check("final_det_held", 32'($signed(det)), 52);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test required completion");
    $fatal(1);
  end

endmodule
